// File: rtl/decode_ctrl_stage.sv
// Main-control decode stage for the RV32I pipeline.
// Decodes the ID instruction, registers it across ID/EX and resolves the EX next-PC select.
module decode_ctrl_stage #(
    parameter bit SUPPORT_UPPER = 1'b1,
    parameter bit BRANCH_FULL   = 1'b1,
    parameter int ILL_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr_d,
    input  logic                 valid_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic                 zero_e,
    input  logic                 lt_e,
    input  logic                 ltu_e,
    output logic                 valid_e,
    output logic                 reg_write_e,
    output logic                 mem_write_e,
    output logic [1:0]           result_src_e,
    output logic                 alu_src_e,
    output logic                 alu_src_a_e,
    output logic [2:0]           imm_src_e,
    output logic [1:0]           alu_op_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic [2:0]           branch_type_e,
    output logic                 illegal_e,
    output logic [1:0]           pcsrc_e,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instr_d[6:0];
    assign funct3            = instr_d[14:12];
    assign unused_instr_bits = ^{instr_d[31:15], instr_d[11:7]};

    logic       reg_write_d;
    logic       mem_write_d;
    logic [1:0] result_src_d;
    logic       alu_src_d;
    logic       alu_src_a_d;
    logic [2:0] imm_src_d;
    logic [1:0] alu_op_d;
    logic       branch_d;
    logic       jump_d;
    logic       jalr_d;
    logic [2:0] branch_type_d;
    logic       illegal_d;

    // Opcode 1:0 is part of every legal opcode, so a non-11 low pair falls to default.
    always_comb begin
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        result_src_d  = 2'b00;
        alu_src_d     = 1'b0;
        alu_src_a_d   = 1'b0;
        imm_src_d     = 3'b000;
        alu_op_d      = 2'b00;
        branch_d      = 1'b0;
        jump_d        = 1'b0;
        jalr_d        = 1'b0;
        branch_type_d = 3'b000;
        illegal_d     = 1'b0;
        case (opcode)
            OP_LOAD: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
            end
            OP_STORE: begin
                imm_src_d   = 3'b001;
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_R: begin
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            OP_I: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = 2'b10;
            end
            OP_BRANCH: begin
                imm_src_d     = 3'b010;
                alu_op_d      = 2'b01;
                branch_d      = 1'b1;
                branch_type_d = funct3;
                if (funct3[2:1] == 2'b01 || (!BRANCH_FULL && funct3 != 3'b000))
                    illegal_d = 1'b1;
            end
            OP_JAL: begin
                reg_write_d  = 1'b1;
                imm_src_d    = 3'b011;
                result_src_d = 2'b10;
                jump_d       = 1'b1;
            end
            OP_JALR: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b10;
                jump_d       = 1'b1;
                jalr_d       = 1'b1;
                if (funct3 != 3'b000)
                    illegal_d = 1'b1;
            end
            OP_LUI: begin
                reg_write_d  = 1'b1;
                imm_src_d    = 3'b100;
                alu_src_d    = 1'b1;
                result_src_d = 2'b11;
                if (!SUPPORT_UPPER)
                    illegal_d = 1'b1;
            end
            OP_AUIPC: begin
                reg_write_d = 1'b1;
                imm_src_d   = 3'b100;
                alu_src_d   = 1'b1;
                alu_src_a_d = 1'b1;
                if (!SUPPORT_UPPER)
                    illegal_d = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            reg_write_d   = 1'b0;
            mem_write_d   = 1'b0;
            result_src_d  = 2'b00;
            alu_src_d     = 1'b0;
            alu_src_a_d   = 1'b0;
            imm_src_d     = 3'b000;
            alu_op_d      = 2'b00;
            branch_d      = 1'b0;
            jump_d        = 1'b0;
            jalr_d        = 1'b0;
            branch_type_d = 3'b000;
        end
    end

    logic [18:0] bundle_d;
    logic [18:0] bundle_q;

    assign bundle_d = {1'b1, reg_write_d, mem_write_d, result_src_d, alu_src_d, alu_src_a_d,
                       imm_src_d, alu_op_d, branch_d, jump_d, jalr_d, branch_type_d, illegal_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bundle_q <= '0;
        else if (flush_e)
            bundle_q <= '0;
        else if (stall_e)
            bundle_q <= bundle_q;
        else if (valid_d)
            bundle_q <= bundle_d;
        else
            bundle_q <= '0;
    end

    // Counting only on a real load means a stalled illegal instruction is seen once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ill_cnt <= '0;
        else if (!flush_e && !stall_e && valid_d && illegal_d && ill_cnt != {ILL_CNT_W{1'b1}})
            ill_cnt <= ill_cnt + ILL_CNT_W'(1);
    end

    assign {valid_e, reg_write_e, mem_write_e, result_src_e, alu_src_e, alu_src_a_e,
            imm_src_e, alu_op_e, branch_e, jump_e, jalr_e, branch_type_e, illegal_e} = bundle_q;

    logic taken;

    always_comb begin
        taken = 1'b0;
        case (branch_type_e)
            3'b000:  taken = zero_e;
            3'b001:  taken = ~zero_e;
            3'b100:  taken = lt_e;
            3'b101:  taken = ~lt_e;
            3'b110:  taken = ltu_e;
            3'b111:  taken = ~ltu_e;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pcsrc_e = 2'b00;
        if (valid_e) begin
            if (jalr_e)
                pcsrc_e = 2'b10;
            else if (jump_e || (branch_e && taken))
                pcsrc_e = 2'b01;
        end
    end

endmodule
